// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle MIPS-subset control unit.
// Covers the FSM states, the opcode map, the mux encodings and the Moore control decode.
package mc_pkg;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, REXEC, RWB, MEMADR, MEMRD, MEMWB,
        MEMWR, BRANCH, IEXEC, IWB, JUMP, TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       alu_imm_and;
        logic       ext_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Moore outputs of a state; opcode only refines BRANCH and IEXEC.
    function automatic ctrl_t ctrl_for(state_t s, logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.pc_source = PCSRC_ALU;
            end
            DECODE: begin
                c.alu_src_b = SRCB_IMM_SH2;
                c.ext_op    = 1'b1;
            end
            REXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALUOP_FUNCT;
            end
            RWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.ext_op    = 1'b1;
            end
            MEMRD: begin
                c.i_or_d   = 1'b1;
                c.mem_read = 1'b1;
            end
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEMWR: begin
                c.i_or_d    = 1'b1;
                c.mem_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_RT;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
                c.branch_ne     = (op == OP_BNE);
            end
            IEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                if (op == OP_ANDI) begin
                    c.alu_op      = ALUOP_OR;
                    c.alu_imm_and = 1'b1;
                end else if (op == OP_ORI) begin
                    c.alu_op = ALUOP_OR;
                end else begin
                    c.alu_op = ALUOP_ADD;
                    c.ext_op = 1'b1;
                end
            end
            IWB: c.reg_write = 1'b1;
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit bundle between the multi-cycle FSM (master) and the datapath (slave).
interface multicycle_control_if #(parameter int RETIRE_W = 32);

    logic [5:0]          Opcode;
    logic                Zero;
    logic                MemReady;
    logic                PCWrite;
    logic                PCWriteCond;
    logic                BranchNe;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                IRWrite;
    logic                MemtoReg;
    logic                RegDst;
    logic                RegWrite;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ALUOp;
    logic                AluImmAnd;
    logic                ExtOp;
    logic [1:0]          PCSource;
    logic                Illegal;
    logic                Timeout;
    logic [RETIRE_W-1:0] Retired;

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, AluImmAnd,
               ExtOp, PCSource, Illegal, Timeout, Retired
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, AluImmAnd,
               ExtOp, PCSource, Illegal, Timeout, Retired
    );

endinterface

// File: rtl/mc_wait_timer.sv
// Counts stalled cycles of a memory state; expired marks the last cycle allowed before a trap.
module mc_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    assign expired = (count == CW'(TIMEOUT - 1));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS-subset datapath.
// Moore controls are registered from the next state; only IRWrite/PCWrite in FETCH follow MemReady.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int TIMEOUT  = 16,
    parameter int RETIRE_W = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    multicycle_control_if.master bus
);

    state_t              state;
    state_t              state_next;
    ctrl_t               ctrl;
    logic [RETIRE_W-1:0] retired;
    logic                illegal;
    logic                timed_out;
    logic                in_mem_state;
    logic                wait_expired;
    logic                retire_now;
    logic                fetch_done;

    assign in_mem_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign retire_now   = (state_next == FETCH) &&
                          (state inside {RWB, MEMWB, MEMWR, BRANCH, IWB, JUMP});

    mc_wait_timer #(.TIMEOUT(TIMEOUT)) wait_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear   (state_next != state),
        .enable  (in_mem_state && !bus.MemReady),
        .expired (wait_expired)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   state_next = FETCH;
            FETCH:  if (bus.MemReady) state_next = DECODE;
                    else if (wait_expired) state_next = TRAP;
            DECODE: begin
                case (bus.Opcode)
                    OP_RTYPE:                 state_next = REXEC;
                    OP_LW, OP_SW:             state_next = MEMADR;
                    OP_BEQ, OP_BNE:           state_next = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_next = IEXEC;
                    OP_J:                     state_next = JUMP;
                    default:                  state_next = TRAP;
                endcase
            end
            REXEC:  state_next = RWB;
            RWB:    state_next = FETCH;
            MEMADR: state_next = (bus.Opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (bus.MemReady) state_next = MEMWB;
                    else if (wait_expired) state_next = TRAP;
            MEMWB:  state_next = FETCH;
            MEMWR:  if (bus.MemReady) state_next = FETCH;
                    else if (wait_expired) state_next = TRAP;
            BRANCH: state_next = FETCH;
            IEXEC:  state_next = IWB;
            IWB:    state_next = FETCH;
            JUMP:   state_next = FETCH;
            TRAP:   state_next = TRAP;
            default: state_next = IDLE;
        endcase
    end

    // Async reset clears the registered controls too, so no enable survives Reset falling.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            ctrl      <= '0;
            illegal   <= 1'b0;
            timed_out <= 1'b0;
            retired   <= '0;
        end else begin
            state <= state_next;
            ctrl  <= ctrl_for(state_next, bus.Opcode);
            if (state == DECODE && state_next == TRAP) begin
                illegal <= 1'b1;
            end
            if (in_mem_state && state_next == TRAP) begin
                timed_out <= 1'b1;
            end
            if (retire_now) begin
                retired <= retired + 1'b1;
            end
        end
    end

    assign fetch_done = (state == FETCH) && bus.MemReady;

    assign bus.PCWrite     = ctrl.pc_write | fetch_done;
    assign bus.IRWrite     = fetch_done;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.BranchNe    = ctrl.branch_ne;
    assign bus.IorD        = ctrl.i_or_d;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.AluImmAnd   = ctrl.alu_imm_and;
    assign bus.ExtOp       = ctrl.ext_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.Illegal     = illegal;
    assign bus.Timeout     = timed_out;
    assign bus.Retired     = retired;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the team's multi-cycle MIPS-subset datapath.
- Sequences fetch, decode, execute, memory and writeback phases.
- Drives every datapath mux and enable, including ExtOp, which selects sign or zero extension of the 16-bit immediate.
- Handshakes with unified instruction/data memory through MemReady.
- Traps on illegal opcodes or memory timeout, and counts retired instructions.

Parameters:
- TIMEOUT, default 16: maximum cycles a memory state waits for MemReady before trapping.
- RETIRE_W, default 32: width of the retired-instruction counter.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- Opcode  in  6  instruction[31:26] from the instruction register.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by the branch condition.
- BranchNe  out  1  branch condition uses !Zero (bne) instead of Zero (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data: 1 = MDR, 0 = ALUOut.
- RegDst  out  1  destination register: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B input: 00 = rt, 01 = 4, 10 = extended immediate, 11 = extended immediate << 2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded, 11 = or; andi is covered by AluImmAnd.
- AluImmAnd  out  1  forces AND when ALUOp = 11.
- ExtOp  out  1  1 = sign-extend, 0 = zero-extend.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- Illegal  out  1  sticky flag: illegal opcode trapped.
- Timeout  out  1  sticky flag: memory timeout trapped.
- Retired  out  RETIRE_W  count of completed instructions.

Behaviour:
- Reset low (asynchronous): state = IDLE; Illegal = Timeout = 0; Retired = 0; wait counter = 0. All control outputs are Moore-decoded from state and are 0 in IDLE.
- IDLE -> FETCH unconditionally on the next clock.
- FETCH: IorD = 0, MemRead = 1.
  - While MemReady = 0: hold.
  - On MemReady = 1: IRWrite = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCWrite = 1, PCSource = 00 (IR and PC update on the same edge); go to DECODE.
  - IRWrite and PCWrite are the only Mealy outputs, gated by MemReady.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00, ExtOp = 1 (branch target precompute). Dispatch on Opcode:
  - 0x00 -> REXEC
  - 0x23 / 0x2B -> MEMADR
  - 0x04 / 0x05 -> BRANCH
  - 0x08 / 0x0C / 0x0D -> IEXEC
  - 0x02 -> JUMP
  - any other -> TRAP, with Illegal set on that edge.
- REXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10 -> RWB.
- RWB: RegDst = 1, MemtoReg = 0, RegWrite = 1 -> FETCH.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ExtOp = 1, ALUOp = 00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: IorD = 1, MemRead = 1; wait for MemReady, then -> MEMWB.
- MEMWB: RegDst = 0, MemtoReg = 1, RegWrite = 1 -> FETCH.
- MEMWR: IorD = 1, MemWrite = 1; wait for MemReady, then -> FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01, BranchNe = (Opcode == 0x05) -> FETCH.
- IEXEC: ALUSrcA = 1, ALUSrcB = 10.
  - addi: ALUOp = 00, ExtOp = 1.
  - andi: ALUOp = 11, AluImmAnd = 1, ExtOp = 0.
  - ori: ALUOp = 11, ExtOp = 0.
  - Then -> IWB.
- IWB: RegDst = 0, MemtoReg = 0, RegWrite = 1 -> FETCH.
- JUMP: PCWrite = 1, PCSource = 10 -> FETCH.
- Opcode is sampled from the IR, which is stable after FETCH; it is not latched separately.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Cleared on entry to each memory state; increments each cycle MemReady = 0.
  - When it reaches TIMEOUT - 1 with MemReady still 0: -> TRAP, Timeout = 1.
  - MemReady = 1 in that same cycle wins: normal completion, no trap.
- TRAP: all controls 0; held until Reset.
- Retired increments by 1 on each transition into FETCH from RWB, MEMWB, MEMWR, BRANCH, IWB or JUMP. It wraps modulo 2^RETIRE_W.
- Reset mid-instruction: immediate return to IDLE, with all enables deasserted asynchronously. No partial write can occur after Reset falls.
- Latencies in cycles, with zero memory wait:
  - R-type 4
  - lw 5
  - sw 4
  - beq / bne 3
  - addi / andi / ori 4
  - j 3

Decomposition:
- Package mc_pkg holds:
  - state enum (IDLE, FETCH, DECODE, REXEC, RWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, IEXEC, IWB, JUMP, TRAP);
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J);
  - ALUOp / ALUSrcB / PCSource encodings.
- One sub-module, mc_wait_timer: the TIMEOUT counter with clear, enable and expired outputs.

Test Plan:
- Reset low, then high with MemReady tied 1 and Opcode = 0x00 -> IDLE, FETCH, DECODE, REXEC, RWB. RegWrite = 1 and RegDst = 1 in cycle 5; Retired = 1 on re-entry to FETCH.
- lw (0x23), MemReady low for 3 cycles in MEMRD -> MemRead and IorD held for 4 cycles, then MEMWB with MemtoReg = 1. ExtOp = 1 in MEMADR.
- andi (0x0C) then ori (0x0D) -> ExtOp = 0 in IEXEC for both; AluImmAnd = 1 only for andi; Retired increments by 2.
- bne (0x05) with Zero = 0 -> BranchNe = 1, PCWriteCond = 1, PCSource = 01 in the third cycle. beq with Zero = 1 -> BranchNe = 0.
- Opcode = 0x3F -> TRAP after DECODE; Illegal = 1; all controls 0 for 10 further cycles. Then Reset low clears Illegal.
- MemReady held 0 in FETCH with TIMEOUT = 16 -> TRAP entered after 16 cycles with Timeout = 1. Repeat with MemReady = 1 on cycle 16 -> normal progress to DECODE, no trap.
